gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx: RTL and testbench
=========================================================

// Module: gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx
// PURPOSE
//  Receive end of the 4-phase REQ/ACK crossing from the 3.3 V I/O domain down into the core domain.
//  Synchronises REQ and captures the DATA bundle into a small FIFO.
//  Presents the captured words to core logic over a VALID/READY interface.
//  Sits directly behind the down-shifter cells on the return path of an up-shifted (lshifup) link.
// PARAMETERS
//  WIDTH        8   data bundle width in bits
//  SYNC_STAGES  2   REQ synchroniser flops; legal range 2..4
//  DEPTH        2   FIFO entries; power of two, 2..8
// PORTS
//  CLK       in   1            core clock; all state updates on rising edge
//  RST       in   1            reset, synchronous, active-high
//  REQ       in   1            async request from sender; DATA is stable while REQ=1
//  DATA      in   WIDTH        async data bundle; sampled only in the capture cycle
//  ACK       out  1            registered acknowledge back to sender
//  Y         out  WIDTH        FIFO head word
//  VALID     out  1            Y holds a valid word
//  READY     in   1            core accepts Y when VALID&&READY at a rising edge
//  FULL      out  1            count==DEPTH; sender is back-pressured
//  XFER_CNT  out  16           count of captured words; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Clocking and reset
//   - One clock (CLK); RST is synchronous, active-high.
//   - While RST=1 at an edge: sync flops=0, state=IDLE, ACK=0, VALID=0, FULL=0, Y=0, XFER_CNT=0, FIFO emptied.
//  Synchroniser
//   - req_s = REQ delayed through SYNC_STAGES flops.
//   - Nothing else samples REQ. DATA bypasses the synchroniser and is captured only in the capture cycle.
//  FSM states: IDLE, ACKED
//   - IDLE: if req_s=1 and count<DEPTH, then in one edge:
//     write DATA at the tail, count+1, XFER_CNT+1, ACK<=1, go to ACKED.
//     If req_s=1 and FULL: stay in IDLE with ACK=0 (stall); capture when space frees.
//   - ACKED: hold ACK=1. When req_s=0: ACK<=0, go to IDLE.
//   - Exactly one capture per REQ high phase.
//  Latency
//   - REQ first sampled high at edge n, FIFO not full: ACK=1 and VALID=1 after edge n+SYNC_STAGES.
//   - REQ sampled low at edge m: ACK=0 after edge m+SYNC_STAGES.
//  FIFO
//   - VALID = (count!=0). Y = head entry, registered storage, no combinational path from DATA.
//   - Pop on VALID&&READY; head advances at the same edge.
//   - Push and pop in the same cycle: count unchanged, both take effect.
//   - Full test uses the pre-edge count: a pop while FULL does not permit a push in that same cycle.
//   - Pointers wrap modulo DEPTH. Y is undefined-free: it holds the last head value when empty.
//   - READY while VALID=0 is ignored.
//  Reset mid-operation
//   - RST during ACKED drops ACK on that edge. Buffered words are lost.
//   - If REQ is still high after reset release, it is treated as a new request and captured
//     again SYNC_STAGES+1 edges later. Senders on this link share the same reset.
// TESTING
//  1 Single word, SYNC_STAGES=2: DATA=8'hA5, REQ up at edge 0, READY=1
//    -> ACK=1 and VALID=1 with Y=8'hA5 after edge 2; VALID=0 after edge 3;
//       REQ down at edge 5 -> ACK=0 after edge 7; XFER_CNT=1.
//  2 Back-pressure, DEPTH=2, READY=0, three transfers 8'h01/8'h02/8'h03
//    -> FULL=1 after the 2nd capture; 3rd REQ held with ACK=0.
//       READY=1 for one cycle -> pops 8'h01, 8'h03 captured one edge later; order 01,02,03 preserved.
//  3 Simultaneous push and pop with count=1 -> count stays 1, Y advances to the new word, XFER_CNT increments.
//  4 REQ pulse of 1 cycle, then held low -> exactly one capture; ACK rises, then falls once REQ low is synchronised.
//  5 RST asserted while in ACKED with 2 words buffered -> next edge: ACK=0, VALID=0, FULL=0, XFER_CNT=0;
//    REQ still high -> recapture, ACK=1 after SYNC_STAGES+1 edges post-release.
//  6 XFER_CNT preloaded (force) to 16'hFFFF, one transfer -> XFER_CNT=16'h0000.

Source files
------------

// File: rtl/gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx_if.sv
// Bundle of the receive-side link signals: the 4-phase REQ/ACK crossing from
// the sender plus the VALID/READY word stream presented to core logic.
// The master side is the environment (sender + core consumer); the slave
// side is the receiver block itself.
interface gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx_if #(
    parameter int WIDTH = 8
);
    logic             REQ;
    logic [WIDTH-1:0] DATA;
    logic             ACK;
    logic [WIDTH-1:0] Y;
    logic             VALID;
    logic             READY;
    logic             FULL;
    logic [15:0]      XFER_CNT;

    modport master (
        output REQ, DATA, READY,
        input  ACK, Y, VALID, FULL, XFER_CNT
    );

    modport slave (
        input  REQ, DATA, READY,
        output ACK, Y, VALID, FULL, XFER_CNT
    );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx.sv
// Receive end of the 4-phase REQ/ACK crossing from the 3.3 V I/O domain into
// the core clock domain. REQ is synchronised; DATA is sampled only in the
// single capture cycle (it is held stable by the sender while REQ is high)
// and written into a small FIFO that feeds core logic over VALID/READY.
module gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_s;

    state_t                 state_q;
    logic                   ack_q;
    logic [15:0]            xfer_cnt_q;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [WIDTH-1:0]       y_q;

    logic                   full;
    logic                   valid;
    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       count_next;
    logic [PTR_W-1:0]       wr_ptr_next;
    logic [PTR_W-1:0]       rd_ptr_next;
    logic [WIDTH-1:0]       head_next;
    logic [WIDTH-1:0]       y_next;

    assign req_s = req_sync_q[SYNC_STAGES-1];

    // Full/valid come from the pre-edge count, so a pop while full never
    // makes room for a push in the same cycle. Y is rebuilt from the
    // post-edge head so it stays a plain register output; when the FIFO
    // drains it simply keeps the last head word.
    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        valid       = (count_q != '0);
        push        = (state_q == IDLE) && req_s && !full;
        pop         = valid && bus.READY;
        count_next  = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_next = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_next = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (push && (wr_ptr_q == rd_ptr_next)) begin
            head_next = bus.DATA;
        end else begin
            head_next = mem_q[rd_ptr_next];
        end
        y_next = (count_next != '0) ? head_next : y_q;
    end

    // REQ synchroniser: the only place the asynchronous request is sampled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.REQ};
        end
    end

    // Handshake FSM: one capture per REQ high phase, ACK held until REQ drops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        ack_q      <= 1'b1;
                        state_q    <= ACKED;
                        xfer_cnt_q <= xfer_cnt_q + 16'd1;
                    end
                end
                ACKED: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO bookkeeping: pointers, occupancy and the registered head word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            y_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_next;
            rd_ptr_q <= rd_ptr_next;
            count_q  <= count_next;
            y_q      <= y_next;
        end
    end

    // FIFO storage: data only, written in the capture cycle, never reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.DATA;
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.Y        = y_q;
    assign bus.VALID    = valid;
    assign bus.FULL     = full;
    assign bus.XFER_CNT = xfer_cnt_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx.sv
// Scoreboard bench for the REQ/ACK receive FIFO: words are queued as the
// sender issues them, and a monitor pops and compares whenever the core side
// accepts a word (VALID && READY).
module tb_gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic rnd_ready = 1'b0;
    logic [WIDTH-1:0] exp_q [$];
    logic [15:0] model_xfer = 16'd0;

    gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx_if #(.WIDTH(WIDTH)) bus ();

    gf180mcu_osu_sc_gp12t3v3_lshifdn_hs_rx #(
        .WIDTH(WIDTH), .SYNC_STAGES(2), .DEPTH(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.READY = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input logic level, input string name);
        int n = 0;
        while (bus.ACK !== level && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(bus.ACK), 32'(level));
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        bus.DATA = d;
        bus.REQ  = 1'b1;
        exp_q.push_back(d);
        model_xfer = model_xfer + 16'd1;
        wait_ack(1'b1, "ack_rise");
        bus.REQ = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        bus.READY = 1'b1;
        repeat (6) tick();
        bus.READY = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        rst       = 1'b1;
        bus.REQ   = 1'b0;
        bus.DATA  = '0;
        bus.READY = 1'b0;

        fork
            // Monitor: compare every accepted word against the scoreboard.
            forever begin
                @(negedge clk);
                if (rst === 1'b0 && bus.VALID === 1'b1 && bus.READY === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_unexpected: got %0h expected no word", bus.Y);
                    end else begin
                        logic [WIDTH-1:0] e;
                        e = exp_q.pop_front();
                        if (bus.Y !== e) begin
                            errors++;
                            $display("FAIL pop_data: got %0h expected %0h", bus.Y, e);
                        end
                    end
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_ack",   32'(bus.ACK),      0);
        check("rst_valid", 32'(bus.VALID),    0);
        check("rst_full",  32'(bus.FULL),     0);
        check("rst_y",     32'(bus.Y),        0);
        check("rst_xfer",  32'(bus.XFER_CNT), 0);
        rst = 1'b0;
        tick();

        // Test 1: single word latency
        bus.READY = 1'b1;
        bus.DATA  = 8'hA5;
        bus.REQ   = 1'b1;
        exp_q.push_back(8'hA5);
        model_xfer = model_xfer + 16'd1;
        tick();  // edge 0
        check("t1_ack_e0", 32'(bus.ACK), 0);
        tick();  // edge 1
        check("t1_ack_e1", 32'(bus.ACK), 0);
        tick();  // edge 2
        check("t1_ack_e2",   32'(bus.ACK),   1);
        check("t1_valid_e2", 32'(bus.VALID), 1);
        check("t1_y_e2",     32'(bus.Y),     32'h A5);
        tick();  // edge 3
        check("t1_valid_e3", 32'(bus.VALID), 0);
        tick();  // edge 4
        bus.REQ = 1'b0;
        tick();  // edge 5
        tick();  // edge 6
        check("t1_ack_e6", 32'(bus.ACK), 1);
        tick();  // edge 7
        check("t1_ack_e7", 32'(bus.ACK), 0);
        check("t1_xfer",   32'(bus.XFER_CNT), 32'(model_xfer));
        bus.READY = 1'b0;

        // Test 2: back-pressure with a full FIFO
        send_word(8'h01);
        send_word(8'h02);
        check("t2_full", 32'(bus.FULL), 1);
        check("t2_head", 32'(bus.Y),    32'h01);
        bus.DATA = 8'h03;
        bus.REQ  = 1'b1;
        exp_q.push_back(8'h03);
        model_xfer = model_xfer + 16'd1;
        repeat (6) tick();
        check("t2_stall_ack",  32'(bus.ACK),  0);
        check("t2_stall_full", 32'(bus.FULL), 1);
        bus.READY = 1'b1;
        tick();
        bus.READY = 1'b0;
        check("t2_nopush_ack",  32'(bus.ACK),  0);
        check("t2_nopush_full", 32'(bus.FULL), 0);
        tick();
        check("t2_cap_ack",  32'(bus.ACK),  1);
        check("t2_cap_full", 32'(bus.FULL), 1);
        check("t2_cap_head", 32'(bus.Y),    32'h02);
        bus.REQ = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        drain();
        check("t2_empty", 32'(bus.VALID), 0);

        // Test 3: push and pop in the same edge with one word buffered
        send_word(8'h10);
        check("t3_valid_pre", 32'(bus.VALID), 1);
        check("t3_y_pre",     32'(bus.Y),     32'h10);
        bus.DATA = 8'h20;
        bus.REQ  = 1'b1;
        exp_q.push_back(8'h20);
        model_xfer = model_xfer + 16'd1;
        tick();
        tick();
        bus.READY = 1'b1;
        tick();
        bus.READY = 1'b0;
        check("t3_ack",   32'(bus.ACK),   1);
        check("t3_valid", 32'(bus.VALID), 1);
        check("t3_full",  32'(bus.FULL),  0);
        check("t3_y",     32'(bus.Y),     32'h20);
        check("t3_xfer",  32'(bus.XFER_CNT), 32'(model_xfer));
        bus.REQ = 1'b0;
        wait_ack(1'b0, "t3_ack_fall");
        drain();

        // Test 4: one-cycle REQ pulse gives exactly one capture
        bus.READY = 1'b1;
        d = 8'($urandom);
        bus.DATA = d;
        bus.REQ  = 1'b1;
        exp_q.push_back(d);
        model_xfer = model_xfer + 16'd1;
        tick();
        bus.REQ = 1'b0;
        wait_ack(1'b1, "t4_ack_rise");
        wait_ack(1'b0, "t4_ack_fall");
        repeat (6) tick();
        check("t4_xfer",  32'(bus.XFER_CNT), 32'(model_xfer));
        check("t4_valid", 32'(bus.VALID),    0);
        bus.READY = 1'b0;

        // Test 5: reset while ACKED with two words buffered
        send_word(8'h5A);
        bus.DATA = 8'hC3;
        bus.REQ  = 1'b1;
        wait_ack(1'b1, "t5_ack_rise");
        check("t5_full_pre", 32'(bus.FULL), 1);
        rst = 1'b1;
        exp_q.delete();
        model_xfer = 16'd0;
        tick();
        check("t5_rst_ack",   32'(bus.ACK),      0);
        check("t5_rst_valid", 32'(bus.VALID),    0);
        check("t5_rst_full",  32'(bus.FULL),     0);
        check("t5_rst_xfer",  32'(bus.XFER_CNT), 0);
        rst = 1'b0;
        exp_q.push_back(8'hC3);
        model_xfer = 16'd1;
        tick();
        check("t5_rel_ack1", 32'(bus.ACK), 0);
        tick();
        check("t5_rel_ack2", 32'(bus.ACK), 0);
        tick();
        check("t5_rel_ack3", 32'(bus.ACK), 1);
        check("t5_rel_xfer", 32'(bus.XFER_CNT), 1);
        bus.REQ = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        drain();

        // Test 6: transfer counter wrap
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        model_xfer = 16'hFFFF;
        send_word(8'h77);
        check("t6_wrap", 32'(bus.XFER_CNT), 32'(model_xfer));
        drain();

        // Randomized traffic with random core back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_word(8'($urandom));
        end
        rnd_ready = 1'b0;
        drain();
        check("rnd_xfer",  32'(bus.XFER_CNT), 32'(model_xfer));
        check("rnd_valid", 32'(bus.VALID),    0);
        check("rnd_left",  32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
